// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing, packet type and small helpers for the CDB arbiter.
package cdb_arbiter_pkg;

   localparam int NUM_REQ   = 4;
   localparam int NUM_CDB   = 2;
   localparam int XLEN      = 32;
   localparam int PTAG_W    = 6;
   localparam int ROB_W     = 5;
   localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CDB_IDX_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
   localparam int CDB_CNT_W = $clog2(NUM_CDB + 1);

   typedef enum logic [1:0] {
      FU_ALU0 = 2'd0,
      FU_ALU1 = 2'd1,
      FU_MDU  = 2'd2,
      FU_LSU  = 2'd3
   } fu_idx_e;

   typedef struct packed {
      logic [PTAG_W-1:0] ptag;
      logic [ROB_W-1:0]  rob_idx;
      logic [XLEN-1:0]   data;
      logic              has_dest;
   } cdb_packet_t;

   localparam int PKT_W = $bits(cdb_packet_t);

   function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx);
      return (idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : idx + REQ_IDX_W'(1);
   endfunction

   function automatic logic [31:0] popcount_cdb(input logic [NUM_CDB-1:0] v);
      logic [31:0] cnt;
      cnt = 32'd0;
      for (int i = 0; i < NUM_CDB; i++) begin
         cnt = cnt + 32'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result request side and CDB broadcast side of the arbiter.
interface cdb_arbiter_if;
   import cdb_arbiter_pkg::*;

   logic                        flush;
   logic        [NUM_REQ-1:0]   req_valid;
   logic        [NUM_REQ-1:0]   req_ready;
   cdb_packet_t [NUM_REQ-1:0]   req_pkt;
   logic        [NUM_CDB-1:0]   cdb_valid;
   cdb_packet_t [NUM_CDB-1:0]   cdb_pkt;

   modport master (
      output flush, req_valid, req_pkt,
      input  req_ready, cdb_valid, cdb_pkt
   );

   modport slave (
      input  flush, req_valid, req_pkt,
      output req_ready, cdb_valid, cdb_pkt
   );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational find-first-NUM_CDB requesters scanning upward from a rotating pointer.
module cdb_arbiter_rr_picker
   import cdb_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0]               req_i,
   input  logic [REQ_IDX_W-1:0]             ptr_i,
   output logic [NUM_REQ-1:0]               grant_o,
   output logic [NUM_CDB-1:0][NUM_REQ-1:0]  sel_o,
   output logic [REQ_IDX_W-1:0]             last_o,
   output logic                             any_o
);

   localparam int SUM_W = REQ_IDX_W + 1;

   logic [SUM_W-1:0]     sum_s;
   logic [REQ_IDX_W-1:0] idx_s;
   logic [CDB_CNT_W-1:0] cnt_s;
   logic                 hit_s;

   // The k-th hit in scan order lands on CDB port k; cnt_s tracks ports used.
   always_comb begin
      grant_o = '0;
      sel_o   = '0;
      last_o  = ptr_i;
      any_o   = 1'b0;
      sum_s   = '0;
      idx_s   = '0;
      cnt_s   = '0;
      hit_s   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum_s = {1'b0, ptr_i} + SUM_W'(k);
         idx_s = (sum_s >= SUM_W'(NUM_REQ)) ? REQ_IDX_W'(sum_s - SUM_W'(NUM_REQ))
                                            : sum_s[REQ_IDX_W-1:0];
         hit_s = req_i[idx_s] && (cnt_s < CDB_CNT_W'(NUM_CDB));
         grant_o[idx_s] = grant_o[idx_s] | hit_s;
         for (int p = 0; p < NUM_CDB; p++) begin
            sel_o[p][idx_s] = sel_o[p][idx_s] | (hit_s && (cnt_s == CDB_CNT_W'(p)));
         end
         last_o = hit_s ? idx_s : last_o;
         any_o  = any_o | hit_s;
         cnt_s  = cnt_s + CDB_CNT_W'(hit_s);
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of FU results onto NUM_CDB registered broadcast ports.
// Define CDB_PERF_EN to add saturating stall/broadcast performance counters.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   cdb_arbiter_if.slave             bus
`ifdef CDB_PERF_EN
   ,
   output logic [NUM_REQ-1:0][31:0] perf_stall_cnt,
   output logic [31:0]              perf_bcast_cnt
`endif
);

   logic        [NUM_REQ-1:0]              req_eff_s;
   logic        [NUM_REQ-1:0]              grant_s;
   logic        [NUM_CDB-1:0][NUM_REQ-1:0] sel_s;
   logic        [REQ_IDX_W-1:0]            last_s;
   logic                                   any_s;
   logic        [REQ_IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic        [NUM_CDB-1:0]              cdb_valid_q, cdb_valid_d;
   cdb_packet_t [NUM_CDB-1:0]              cdb_pkt_q, cdb_pkt_d;
   logic        [NUM_CDB-1:0][PKT_W-1:0]   mux_s;

   // Nothing is grantable while flushing or held in reset.
   always_comb begin
      if (rst || bus.flush) begin
         req_eff_s = '0;
      end else begin
         req_eff_s = bus.req_valid;
      end
   end

   cdb_arbiter_rr_picker u_picker (
      .req_i   (req_eff_s),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant_s),
      .sel_o   (sel_s),
      .last_o  (last_s),
      .any_o   (any_s)
   );

   assign bus.req_ready = grant_s;

   always_comb begin
      mux_s = '0;
      for (int p = 0; p < NUM_CDB; p++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            mux_s[p] = mux_s[p] | ({PKT_W{sel_s[p][r]}} & bus.req_pkt[r]);
         end
      end
   end

   // Idle ports keep their old payload so only valid bits toggle.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = '0;
      cdb_pkt_d   = cdb_pkt_q;
      if (bus.flush) begin
         rr_ptr_d = '0;
      end else if (any_s) begin
         rr_ptr_d = rr_next(last_s);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      for (int p = 0; p < NUM_CDB; p++) begin
         cdb_valid_d[p] = |sel_s[p];
         cdb_pkt_d[p]   = cdb_valid_d[p] ? cdb_packet_t'(mux_s[p]) : cdb_pkt_q[p];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= '0;
         cdb_pkt_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_pkt_q   <= cdb_pkt_d;
      end
   end

   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_pkt   = cdb_pkt_q;

`ifdef CDB_PERF_EN
   logic [NUM_REQ-1:0][31:0] stall_q, stall_d;
   logic [31:0]              bcast_q, bcast_d;
   logic [32:0]              bcast_sum_s;

   // Counters saturate rather than wrap; flush leaves them untouched.
   always_comb begin
      stall_d = stall_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_valid[i] && !grant_s[i] && !bus.flush && (stall_q[i] != 32'hFFFF_FFFF)) begin
            stall_d[i] = stall_q[i] + 32'd1;
         end else begin
            stall_d[i] = stall_q[i];
         end
      end
      bcast_sum_s = {1'b0, bcast_q} + {1'b0, popcount_cdb(cdb_valid_q)};
      if (bcast_sum_s[32]) begin
         bcast_d = 32'hFFFF_FFFF;
      end else begin
         bcast_d = bcast_sum_s[31:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         bcast_q <= 32'd0;
      end else begin
         stall_q <= stall_d;
         bcast_q <= bcast_d;
      end
   end

   assign perf_stall_cnt = stall_q;
   assign perf_bcast_cnt = bcast_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts queued at grant time, checked one cycle later.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   typedef struct packed {
      logic        [NUM_CDB-1:0] valid;
      cdb_packet_t [NUM_CDB-1:0] pkt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cdb_arbiter_if bus_if ();

`ifdef CDB_PERF_EN
   logic [NUM_REQ-1:0][31:0] perf_stall_cnt;
   logic [31:0]              perf_bcast_cnt;
`endif

   cdb_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus_if)
`ifdef CDB_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_bcast_cnt (perf_bcast_cnt)
`endif
   );

   always #5 clk = ~clk;

   int                 n_vec    = 0;
   int                 n_err    = 0;
   int                 m_ptr    = 0;
   int                 bc_tally = 0;
   exp_t               exp_q[$];
   cdb_packet_t        pkt_tb [NUM_REQ];
   logic [NUM_REQ-1:0] held     = '0;
   logic [NUM_REQ-1:0] rdy;

   task automatic model_reset();
      m_ptr = 0;
      held  = '0;
      exp_q.delete();
   endtask

   task automatic refresh_pkts();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!held[i]) begin
            pkt_tb[i].ptag     = PTAG_W'($urandom);
            pkt_tb[i].rob_idx  = ROB_W'($urandom);
            pkt_tb[i].data     = $urandom;
            pkt_tb[i].has_dest = 1'($urandom);
         end
      end
   endtask

   // One clock of stimulus: check grants before the edge, check the broadcast after it.
   task automatic apply(input logic [NUM_REQ-1:0] v, input logic fl, output logic [NUM_REQ-1:0] r);
      exp_t               e;
      logic [NUM_REQ-1:0] g;
      int                 k;
      int                 idx;
      int                 nxt;
      bus_if.req_valid = v;
      bus_if.flush     = fl;
      for (int i = 0; i < NUM_REQ; i++) bus_if.req_pkt[i] = pkt_tb[i];
      #1;
      g   = '0;
      e   = '0;
      k   = 0;
      nxt = m_ptr;
      if (fl == 1'b0) begin
         for (int s = 0; s < NUM_REQ; s++) begin
            idx = (m_ptr + s) % NUM_REQ;
            if (v[idx[REQ_IDX_W-1:0]] && (k < NUM_CDB)) begin
               g[idx[REQ_IDX_W-1:0]]     = 1'b1;
               e.valid[k[CDB_IDX_W-1:0]] = 1'b1;
               e.pkt[k[CDB_IDX_W-1:0]]   = pkt_tb[idx[REQ_IDX_W-1:0]];
               k   = k + 1;
               nxt = (idx + 1) % NUM_REQ;
            end
         end
      end else begin
         nxt = 0;
      end
      m_ptr = nxt;
      r     = bus_if.req_ready;
      n_vec++;
      if (bus_if.req_ready !== g) begin
         n_err++;
         $display("FAIL req_ready: got %b want %b (valid %b flush %b)", bus_if.req_ready, g, v, fl);
      end
      held = v & ~g;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (bus_if.cdb_valid !== e.valid) begin
         n_err++;
         $display("FAIL cdb_valid: got %b want %b", bus_if.cdb_valid, e.valid);
      end
      for (int p = 0; p < NUM_CDB; p++) begin
         if (e.valid[p]) begin
            n_vec++;
            if (bus_if.cdb_pkt[p] !== e.pkt[p]) begin
               n_err++;
               $display("FAIL cdb_pkt[%0d]: got %h want %h", p, bus_if.cdb_pkt[p], e.pkt[p]);
            end
         end
      end
      bc_tally = bc_tally + int'(popcount_cdb(e.valid));
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      bus_if.flush     = 1'b0;
      bus_if.req_valid = 4'b1111;
      refresh_pkts();
      for (int i = 0; i < NUM_REQ; i++) bus_if.req_pkt[i] = pkt_tb[i];
      repeat (2) @(negedge clk);
      n_vec++;
      if (bus_if.req_ready !== 4'b0000) begin
         n_err++; $display("FAIL reset_ready: got %b want 0000", bus_if.req_ready);
      end
      n_vec++;
      if (bus_if.cdb_valid !== 2'b00) begin
         n_err++; $display("FAIL reset_cdb_valid: got %b want 00", bus_if.cdb_valid);
      end
      n_vec++;
      if (bus_if.cdb_pkt !== '0) begin
         n_err++; $display("FAIL reset_cdb_pkt: got %h want 0", bus_if.cdb_pkt);
      end
      rst = 1'b0;
      model_reset();
      apply(4'b1111, 1'b0, rdy);
      n_vec++;
      if (rdy !== 4'b0011) begin
         n_err++; $display("FAIL first_grant: got %b want 0011", rdy);
      end
      refresh_pkts();
      apply(4'b1111, 1'b0, rdy);
      n_vec++;
      if (rdy !== 4'b1100) begin
         n_err++; $display("FAIL second_grant: got %b want 1100", rdy);
      end
      refresh_pkts();
      apply(4'b0001, 1'b0, rdy);
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (bus_if.cdb_valid !== 2'b00) begin
         n_err++; $display("FAIL midop_reset_valid: got %b want 00", bus_if.cdb_valid);
      end
      n_vec++;
      if (bus_if.req_ready !== 4'b0000) begin
         n_err++; $display("FAIL midop_reset_ready: got %b want 0000", bus_if.req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      refresh_pkts();
      pkt_tb[2].ptag     = 6'd7;
      pkt_tb[2].data     = 32'hDEADBEEF;
      pkt_tb[2].has_dest = 1'b1;
      apply(4'b0100, 1'b0, rdy);
      n_vec++;
      if (rdy !== 4'b0100) begin
         n_err++; $display("FAIL single_ready: got %b want 0100", rdy);
      end
      n_vec++;
      if ((bus_if.cdb_valid !== 2'b01) || (bus_if.cdb_pkt[0].ptag !== 6'd7) ||
          (bus_if.cdb_pkt[0].data !== 32'hDEADBEEF)) begin
         n_err++;
         $display("FAIL single_bcast: got valid %b ptag %0d data %h want 01 7 deadbeef",
                  bus_if.cdb_valid, bus_if.cdb_pkt[0].ptag, bus_if.cdb_pkt[0].data);
      end
   endtask

   task automatic test_contention();
      logic [NUM_REQ-1:0] want [4];
      want = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
      apply(4'b0000, 1'b1, rdy);
      for (int c = 0; c < 4; c++) begin
         refresh_pkts();
         apply(4'b1111, 1'b0, rdy);
         n_vec++;
         if (rdy !== want[c]) begin
            n_err++; $display("FAIL contention_%0d: got %b want %b", c, rdy, want[c]);
         end
      end
   endtask

   task automatic test_wrap();
      apply(4'b0000, 1'b1, rdy);
      refresh_pkts();
      apply(4'b0100, 1'b0, rdy);
      refresh_pkts();
      apply(4'b1001, 1'b0, rdy);
      n_vec++;
      if (rdy !== 4'b1001) begin
         n_err++; $display("FAIL wrap_ready: got %b want 1001", rdy);
      end
      n_vec++;
      if ((bus_if.cdb_pkt[0] !== pkt_tb[3]) || (bus_if.cdb_pkt[1] !== pkt_tb[0])) begin
         n_err++;
         $display("FAIL wrap_order: got %h %h want %h %h",
                  bus_if.cdb_pkt[0], bus_if.cdb_pkt[1], pkt_tb[3], pkt_tb[0]);
      end
      refresh_pkts();
      apply(4'b1111, 1'b0, rdy);
      n_vec++;
      if (rdy !== 4'b0110) begin
         n_err++; $display("FAIL wrap_ptr: got %b want 0110", rdy);
      end
   endtask

   task automatic test_flush();
      refresh_pkts();
      apply(4'b1111, 1'b0, rdy);
      n_vec++;
      if (bus_if.cdb_valid !== 2'b11) begin
         n_err++; $display("FAIL preflush_valid: got %b want 11", bus_if.cdb_valid);
      end
      apply(4'b1111, 1'b1, rdy);
      n_vec++;
      if (rdy !== 4'b0000) begin
         n_err++; $display("FAIL flush_ready: got %b want 0000", rdy);
      end
      n_vec++;
      if (bus_if.cdb_valid !== 2'b00) begin
         n_err++; $display("FAIL flush_clear: got %b want 00", bus_if.cdb_valid);
      end
      refresh_pkts();
      apply(4'b1111, 1'b0, rdy);
      n_vec++;
      if (rdy !== 4'b0011) begin
         n_err++; $display("FAIL flush_ptr: got %b want 0011", rdy);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 40; c++) begin
         refresh_pkts();
         apply(NUM_REQ'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), rdy);
      end
   endtask

   task automatic test_perf();
`ifdef CDB_PERF_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      bc_tally = 0;
      n_vec++;
      if ((perf_stall_cnt !== '0) || (perf_bcast_cnt !== 32'd0)) begin
         n_err++; $display("FAIL perf_reset: got %h %h want 0", perf_stall_cnt, perf_bcast_cnt);
      end
      refresh_pkts();
      apply(4'b0111, 1'b0, rdy);
      apply(4'b0111, 1'b1, rdy);
      refresh_pkts();
      apply(4'b0111, 1'b0, rdy);
      apply(4'b0111, 1'b1, rdy);
      refresh_pkts();
      apply(4'b0111, 1'b0, rdy);
      apply(4'b0100, 1'b0, rdy);
      apply(4'b0000, 1'b0, rdy);
      n_vec++;
      if (perf_stall_cnt[2] !== 32'd3) begin
         n_err++; $display("FAIL perf_stall2: got %0d want 3", perf_stall_cnt[2]);
      end
      n_vec++;
      if ((perf_stall_cnt[0] !== 32'd0) || (perf_stall_cnt[1] !== 32'd0) || (perf_stall_cnt[3] !== 32'd0)) begin
         n_err++; $display("FAIL perf_stall_other: got %h want 0 for 0,1,3", perf_stall_cnt);
      end
      n_vec++;
      if (perf_bcast_cnt !== 32'(bc_tally)) begin
         n_err++; $display("FAIL perf_bcast: got %0d want %0d", perf_bcast_cnt, bc_tally);
      end
`endif
   endtask

   initial begin
      bus_if.flush     = 1'b0;
      bus_if.req_valid = '0;
      bus_if.req_pkt   = '0;
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_flush();
      test_back_to_back();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
